// File: rtl/trig_pkg.sv
// Shared definitions for the trigger input conditioner: FSM state encoding,
// SRC_SEL bit positions and the command pulse length.
package trig_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MEASURE = 3'd1,
      ST_FIRE    = 3'd2,
      ST_HOLDOFF = 3'd3,
      ST_SYNC    = 3'd4
   } trig_state_t;

   localparam int SRC_HW_BIT = 0;
   localparam int SRC_SW_BIT = 1;

   // TRIG_CMD / RESET_CMD width in CLK cycles, and the counter that times it
   localparam int PULSE_LEN   = 2;
   localparam int PULSE_CNT_W = (PULSE_LEN > 2) ? $clog2(PULSE_LEN) : 1;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a third flop that
// turns the synchronised level into a one-cycle rise pulse.
module sync_edge (
   input  logic CLK,
   input  logic RST,
   input  logic async_in,
   output logic level,
   output logic rise
);

   logic [2:0] sr;

   // shift the raw input through the metastability and edge-detect stages
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sr <= '0;
      else     sr <= {sr[1:0], async_in};
   end

   assign level = sr[1];
   assign rise  = sr[1] & ~sr[2];

endmodule

// File: rtl/trig_input_cond.sv
// Trigger input conditioner feeding the APV trigger generator.
// Synchronises TRIG_IN/SYNC_IN, merges software pulses, filters short
// trigger glitches, enforces a hold-off and counts rejected triggers.
// Build option: define TRIG_TIMESTAMP_EN to add the TRIG_TSTAMP output.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for a trigger or sync request
//   MEASURE | trigger line high, counting its width against MIN_WIDTH
//   FIRE    | trigger accepted; TRIG_CMD driven for the next 2 cycles
//   HOLDOFF | dead time after a trigger; new triggers counted as rejects
//   SYNC    | sync accepted; RESET_CMD driven for the next 2 cycles
module trig_input_cond
   import trig_pkg::*;
#(
   parameter int HOLDOFF_W = 8,
   parameter int REJ_CNT_W = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 TRIG_IN,
   input  logic                 SYNC_IN,
   input  logic                 SW_TRIG,
   input  logic                 SW_SYNC,
   input  logic [1:0]           SRC_SEL,
   input  logic [3:0]           MIN_WIDTH,
   input  logic [HOLDOFF_W-1:0] HOLDOFF,
   output logic                 TRIG_CMD,
   output logic                 RESET_CMD,
   output logic                 BUSY,
   output logic [REJ_CNT_W-1:0] TRIG_REJECT_CNT
`ifdef TRIG_TIMESTAMP_EN
   ,
   output logic [31:0]          TRIG_TSTAMP
`endif
);

   trig_state_t            state;
   logic [3:0]             wcnt;
   logic [3:0]             min_w_q;
   logic [HOLDOFF_W-1:0]   hcnt;
   logic [PULSE_CNT_W-1:0] pcnt;

   logic trig_s, trig_rise;
   logic sync_s, sync_rise;
   logic hw_en, sw_en;
   logic trig_hw, trig_sw, trig_any, sync_any;
   logic pulse_done, rej_inc;

   sync_edge u_trig_sync (
      .CLK      (CLK),
      .RST      (RST),
      .async_in (TRIG_IN),
      .level    (trig_s),
      .rise     (trig_rise)
   );

   sync_edge u_sync_sync (
      .CLK      (CLK),
      .RST      (RST),
      .async_in (SYNC_IN),
      .level    (sync_s),
      .rise     (sync_rise)
   );

   assign hw_en    = SRC_SEL[SRC_HW_BIT];
   assign sw_en    = SRC_SEL[SRC_SW_BIT];
   assign trig_hw  = trig_rise & hw_en;
   assign trig_sw  = SW_TRIG & sw_en;
   assign trig_any = trig_hw | trig_sw;
   // a rise already implies the level is high; the AND keeps both
   // synchroniser instances on the same interface
   assign sync_any = (sync_rise & sync_s & hw_en) | (SW_SYNC & sw_en);

   assign pulse_done = (pcnt == PULSE_CNT_W'(PULSE_LEN - 1));

   // glitch rejects in MEASURE and any trigger during hold-off; a
   // simultaneous sync always takes the trigger away uncounted
   assign rej_inc = ~sync_any &
                    (((state == ST_MEASURE) & ~trig_s) |
                     ((state == ST_HOLDOFF) & trig_any));

   assign BUSY = (state != ST_IDLE);

   // trigger FSM with registered command outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         wcnt      <= '0;
         min_w_q   <= '0;
         hcnt      <= '0;
         pcnt      <= '0;
         TRIG_CMD  <= 1'b0;
         RESET_CMD <= 1'b0;
      end else begin
         TRIG_CMD  <= (state == ST_FIRE);
         RESET_CMD <= (state == ST_SYNC);
         case (state)
            ST_IDLE: begin
               if (sync_any) begin
                  state <= ST_SYNC;
                  pcnt  <= '0;
               end else if (trig_sw) begin
                  state <= ST_FIRE;
                  pcnt  <= '0;
               end else if (trig_hw) begin
                  if (MIN_WIDTH == 4'd0) begin
                     state <= ST_FIRE;
                     pcnt  <= '0;
                  end else begin
                     state   <= ST_MEASURE;
                     wcnt    <= 4'd1;
                     min_w_q <= MIN_WIDTH;
                  end
               end
            end
            ST_MEASURE: begin
               if (sync_any) begin
                  state <= ST_SYNC;
                  pcnt  <= '0;
               end else if (!trig_s) begin
                  state <= ST_IDLE;
               end else if (wcnt == min_w_q) begin
                  state <= ST_FIRE;
                  pcnt  <= '0;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            ST_FIRE: begin
               if (pulse_done) begin
                  if (HOLDOFF == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_HOLDOFF;
                     hcnt  <= HOLDOFF;
                  end
               end else begin
                  pcnt <= pcnt + PULSE_CNT_W'(1);
               end
            end
            ST_HOLDOFF: begin
               if (sync_any) begin
                  state <= ST_SYNC;
                  pcnt  <= '0;
               end else if (hcnt == HOLDOFF_W'(1)) begin
                  state <= ST_IDLE;
               end else begin
                  hcnt <= hcnt - HOLDOFF_W'(1);
               end
            end
            ST_SYNC: begin
               if (pulse_done) state <= ST_IDLE;
               else            pcnt  <= pcnt + PULSE_CNT_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // saturating reject counter; a sync clears it and beats any increment
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                               TRIG_REJECT_CNT <= '0;
      else if (state == ST_SYNC)             TRIG_REJECT_CNT <= '0;
      else if (rej_inc && (TRIG_REJECT_CNT != '1))
         TRIG_REJECT_CNT <= TRIG_REJECT_CNT + REJ_CNT_W'(1);
   end

`ifdef TRIG_TIMESTAMP_EN
   logic [31:0] ts_cnt;

   // free-running timestamp, cleared by sync, captured as TRIG_CMD rises
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ts_cnt      <= '0;
         TRIG_TSTAMP <= '0;
      end else begin
         ts_cnt <= (state == ST_SYNC) ? 32'd0 : ts_cnt + 32'd1;
         if ((state == ST_FIRE) && !TRIG_CMD) TRIG_TSTAMP <= ts_cnt;
      end
   end
`endif

endmodule

// File: doc/trig_input_cond.md
Name: trig_input_cond

Overview:
Front-end conditioner that sits directly upstream of the APV trigger generator and drives its TRIG_CMD and RESET_CMD inputs.
- Synchronises the asynchronous front-panel trigger and sync lines to CLK and merges them with software-issued pulses.
- Rejects glitches narrower than a programmable minimum width.
- Enforces a programmable hold-off after each accepted trigger.
- Counts rejected triggers for readout.

Parameters:
HOLDOFF_W, 8, width of the HOLDOFF register and hold-off counter
REJ_CNT_W, 16, width of TRIG_REJECT_CNT

Ports:
CLK  in  1  system clock; sole clock of the block
RST  in  1  asynchronous, active-high reset
TRIG_IN  in  1  external trigger, asynchronous to CLK
SYNC_IN  in  1  external sync/reset request, asynchronous to CLK
SW_TRIG  in  1  one-cycle software trigger, synchronous to CLK
SW_SYNC  in  1  one-cycle software sync, synchronous to CLK
SRC_SEL  in  2  bit0 enables hardware lines, bit1 enables software pulses
MIN_WIDTH  in  4  minimum TRIG_IN high time in CLK cycles; 0 disables the filter
HOLDOFF  in  HOLDOFF_W  dead cycles after each accepted trigger
TRIG_CMD  out  1  two-cycle trigger pulse to the trigger generator
RESET_CMD  out  1  two-cycle reset pulse to the trigger generator
BUSY  out  1  high while the FSM is outside IDLE
TRIG_REJECT_CNT  out  REJ_CNT_W  glitch plus hold-off rejections; saturating

Behaviour:
- Reset: RST=1 asynchronously clears all flops. TRIG_CMD=0, RESET_CMD=0, BUSY=0, TRIG_REJECT_CNT=0, FSM=IDLE, synchronisers=0.
- Synchronisers: TRIG_IN and SYNC_IN each pass through 2 flops, producing trig_s and sync_s.
- Edge detection:
  - A third flop gives the rise pulses trig_rise and sync_rise.
  - Each rise pulse is gated by SRC_SEL[0].
  - SW_TRIG and SW_SYNC are gated by SRC_SEL[1] and bypass the synchronisers.
- Trigger FSM (registered):
  - IDLE:
    - On sync_any (gated sync_rise or SW_SYNC), go to SYNC.
    - Else on gated SW_TRIG, go to FIRE.
    - Else on gated trig_rise: if MIN_WIDTH==0 go to FIRE; otherwise set wcnt=1 and go to MEASURE.
  - MEASURE:
    - If trig_s==0, increment the reject counter and go to IDLE.
    - Else if wcnt==MIN_WIDTH, go to FIRE.
    - Else increment wcnt.
    - A sync_any in MEASURE aborts the trigger without counting it and goes to SYNC.
  - FIRE: stays 2 cycles, then loads hcnt=HOLDOFF and goes to HOLDOFF, or to IDLE if HOLDOFF==0.
  - HOLDOFF:
    - Decrements hcnt and goes to IDLE when hcnt reaches 1.
    - Every gated trig_rise or SW_TRIG seen here increments the reject counter.
    - A sync_any here goes to SYNC immediately.
  - SYNC: stays 2 cycles, then returns to IDLE. The hold-off is abandoned.
- Outputs:
  - TRIG_CMD is registered and equals 1 in the cycles after the FSM is in FIRE, so it is exactly 2 cycles wide.
  - RESET_CMD behaves the same way for SYNC.
  - TRIG_CMD and RESET_CMD are never simultaneously high.
- Priority: when a trigger and a sync arrive in the same cycle, sync wins and the trigger is dropped without being counted.
- Latency:
  - TRIG_IN rise to TRIG_CMD rise = MIN_WIDTH+4 cycles, or 4 when MIN_WIDTH=0 (setup met).
  - SW_TRIG to TRIG_CMD = 2 cycles.
- TRIG_REJECT_CNT:
  - Saturates at all-ones; it never wraps.
  - Cleared when RESET_CMD asserts; the clear wins over an increment in the same cycle.
- MIN_WIDTH and HOLDOFF are sampled only at state entry; changes mid-operation take effect on the next trigger.
- BUSY = (FSM != IDLE).

Optional Feature:
TRIG_TIMESTAMP_EN
- Defined:
  - Adds output TRIG_TSTAMP[31:0] and a free-running 32-bit counter.
  - The counter is cleared when RESET_CMD asserts and wraps modulo 2^32.
  - The counter value is latched into TRIG_TSTAMP on the cycle TRIG_CMD rises.
  - TRIG_TSTAMP resets to 0.
- Undefined: the port, the counter and the latch are absent; all other behaviour is identical.

Decomposition:
- Shared package (trig_pkg) holds:
  - FSM state encoding constants: IDLE=0, MEASURE=1, FIRE=2, HOLDOFF=3, SYNC=4.
  - SRC_SEL bit-index constants.
  - The 2-cycle output pulse length constant.
- One natural sub-module, sync_edge: 2-flop synchroniser plus rise detector with async active-high reset. It is instantiated twice, for TRIG_IN and SYNC_IN.

Test Plan:
- SRC_SEL=01, MIN_WIDTH=3, HOLDOFF=10, TRIG_IN high for 6 cycles -> TRIG_CMD high exactly 2 cycles starting 7 cycles after the input rise; BUSY returns to 0 after hold-off; TRIG_REJECT_CNT=0.
- MIN_WIDTH=5, TRIG_IN pulses of 2 cycles, repeated 3 times with gaps of 30 cycles -> TRIG_CMD stays 0; TRIG_REJECT_CNT=3.
- HOLDOFF=20, two TRIG_IN rises 8 cycles apart (MIN_WIDTH=0) -> one TRIG_CMD; TRIG_REJECT_CNT=1; a third rise 40 cycles later is accepted.
- SRC_SEL=10, SW_SYNC and SW_TRIG in the same cycle -> RESET_CMD 2 cycles wide, no TRIG_CMD; counter cleared to 0.
- RST asserted while in HOLDOFF with TRIG_REJECT_CNT=5 -> all outputs 0 asynchronously; first trigger after release is accepted with 4-cycle latency.
- REJ_CNT_W=4, force 20 hold-off rejections -> TRIG_REJECT_CNT holds at 15, no wrap.
